// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//
// Instruction-side responder for the fetch stage. A single line buffer of
// LINE_WORDS words sits in front of a backing instruction memory. Hits
// return the addressed word one cycle after the address is presented, just
// like a synchronous-read memory. A miss raises i_stall, issues one
// line-aligned request over the valid/ready channel, then collects
// LINE_WORDS response beats in ascending word order before releasing the
// stall.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   i_addr         fetch address (bits [1:0] ignored)
//   hold           pipeline stalled elsewhere; instr must not change
//   invalidate     fence.i pulse; clears the line buffer
//   instr          word for the address presented in the previous cycle
//   i_stall        miss or fill in progress; fetch must hold its address
//   mem_req_valid  line request valid
//   mem_req_ready  backing memory accepts the request
//   mem_req_addr   line-aligned request address
//   mem_rsp_valid  response beat valid
//   mem_rsp_data   response beat data
// ---------------------------------------------------------------------------
module imem_responder #(
  parameter int          LINE_WORDS = 4,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_addr,
  input  logic        hold,
  input  logic        invalidate,
  output logic [31:0] instr,
  output logic        i_stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF   = IDX_W + 2;
  localparam int TAG_W = 32 - OFF;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL
  } state_t;

  state_t             state_q, state_d;
  logic               line_valid_q, line_valid_d;
  logic [TAG_W-1:0]   line_tag_q, line_tag_d;
  logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               discard_q, discard_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        line_q [LINE_WORDS];
  logic [31:0]        line_d [LINE_WORDS];

  logic [TAG_W-1:0]   addr_tag;
  logic [IDX_W-1:0]   addr_idx;
  logic               hit;
  logic               last_beat;
  logic               unused_addr_bits;

  assign addr_tag         = i_addr[31:OFF];
  assign addr_idx         = i_addr[OFF-1:2];
  assign unused_addr_bits = ^i_addr[1:0];

  // A hit is only honoured while idle; during REQ/FILL the buffer is being
  // rewritten and the presented address is ignored.
  assign hit       = (state_q == IDLE) & line_valid_q & (addr_tag == line_tag_q);
  assign i_stall   = (state_q != IDLE) | ~hit;
  assign last_beat = mem_rsp_valid & (cnt_q == LAST_IDX);
  assign instr     = instr_q;

  // State register: control state is reset, line contents are not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      line_valid_q <= 1'b0;
      line_tag_q   <= '0;
      miss_tag_q   <= '0;
      cnt_q        <= '0;
      discard_q    <= 1'b0;
      instr_q      <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      line_valid_q <= line_valid_d;
      line_tag_q   <= line_tag_d;
      miss_tag_q   <= miss_tag_d;
      cnt_q        <= cnt_d;
      discard_q    <= discard_d;
      instr_q      <= instr_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LINE_WORDS; i++) begin
      line_q[i] <= line_d[i];
    end
  end

  // Next-state logic. There is no abort path: once a request is issued the
  // whole line is consumed before returning to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!hit)          state_d = REQ;
      REQ:  if (mem_req_ready) state_d = FILL;
      FILL: if (last_beat)     state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // FSM outputs. The request address comes straight from the latched miss
  // tag so it stays stable for the whole REQ wait.
  always_comb begin
    mem_req_valid = (state_q == REQ);
    mem_req_addr  = {miss_tag_q, {OFF{1'b0}}};
  end

  // Datapath updates for each state.
  always_comb begin
    line_valid_d = line_valid_q;
    line_tag_d   = line_tag_q;
    miss_tag_d   = miss_tag_q;
    cnt_d        = cnt_q;
    discard_d    = discard_q;
    instr_d      = instr_q;
    for (int i = 0; i < LINE_WORDS; i++) begin
      line_d[i] = line_q[i];
    end

    case (state_q)
      IDLE: begin
        if (hit && !hold) begin
          instr_d = line_q[addr_idx];
        end
        if (!hit) begin
          miss_tag_d = addr_tag;
        end
        if (invalidate) begin
          line_valid_d = 1'b0;
        end
      end

      REQ: begin
        // An invalidate while a line is in flight cannot cancel it, so it
        // is remembered and applied when the fill finishes.
        if (invalidate) begin
          discard_d = 1'b1;
        end
        if (mem_req_ready) begin
          cnt_d        = '0;
          line_valid_d = 1'b0;
        end
      end

      FILL: begin
        if (mem_rsp_valid) begin
          line_d[cnt_q] = mem_rsp_data;
          cnt_d         = cnt_q + IDX_W'(1);
        end
        if (last_beat) begin
          line_tag_d   = miss_tag_q;
          line_valid_d = ~discard_q & ~invalidate;
          discard_d    = 1'b0;
        end else if (invalidate) begin
          discard_d = 1'b1;
        end
      end

      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_imem_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_responder
//
// Directed vector table covering the fill, hit, hold, stalled-request and
// invalidate scenarios, a hand-written asynchronous reset in the middle of
// a fill, then a randomized run against a behavioural model of the
// responder and its backing memory.
// ---------------------------------------------------------------------------
module tb_imem_responder;

  localparam int          LW  = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_addr = '0;
  logic        hold = 1'b0;
  logic        invalidate = 1'b0;
  logic [31:0] instr;
  logic        i_stall;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_responder #(
    .LINE_WORDS(LW),
    .NOP_INSTR (NOP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_addr       (i_addr),
    .hold         (hold),
    .invalidate   (invalidate),
    .instr        (instr),
    .i_stall      (i_stall),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data)
  );

  typedef struct {
    logic [31:0] addr;
    logic        hold;
    logic        inv;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        exp_stall;
    logic        exp_mrv;
    logic        chk_maddr;
    logic [31:0] exp_maddr;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] addr, input logic h, input logic iv,
                              input logic rdy, input logic rv, input logic [31:0] rdata,
                              input logic st, input logic mrv, input logic chk,
                              input logic [31:0] maddr, input logic [31:0] ins);
    vec_t v;
    v.addr = addr; v.hold = h; v.inv = iv; v.rdy = rdy; v.rv = rv; v.rdata = rdata;
    v.exp_stall = st; v.exp_mrv = mrv; v.chk_maddr = chk; v.exp_maddr = maddr;
    v.exp_instr = ins;
    return v;
  endfunction

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h01234567;
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & ~(32'(LW * 4) - 32'd1);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    i_addr        = v.addr;
    hold          = v.hold;
    invalidate    = v.inv;
    mem_req_ready = v.rdy;
    mem_rsp_valid = v.rv;
    mem_rsp_data  = v.rdata;
  endtask

  task automatic checkOutput(input int row, input vec_t v);
    cmp($sformatf("row%0d_instr", row), instr, v.exp_instr);
    cmp($sformatf("row%0d_stall", row), {31'd0, i_stall}, {31'd0, v.exp_stall});
    cmp($sformatf("row%0d_reqvalid", row), {31'd0, mem_req_valid}, {31'd0, v.exp_mrv});
    if (v.chk_maddr) cmp($sformatf("row%0d_reqaddr", row), mem_req_addr, v.exp_maddr);
  endtask

  // Each row: drive inputs shortly after a rising edge, check during the
  // cycle, then let the next edge happen.
  task automatic runRows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput(i, vecs[i]);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idleInputs(input logic [31:0] a);
    i_addr = a; hold = 0; invalidate = 0; mem_req_ready = 0;
    mem_rsp_valid = 0; mem_rsp_data = '0;
  endtask

  // Randomized-run model state
  logic        m_pending;
  int          m_beats_left;
  logic        m_valid;
  logic [31:0] m_line;
  logic [31:0] m_req_line;
  logic        m_discard;
  logic [31:0] exp_instr;

  initial begin
    logic [31:0] lines [4];
    logic [31:0] a, rd;
    logic h, iv, rdy, rv, idle, hit;
    int part_a_last;

    // ---------------- directed table ----------------
    // Reset release, first miss, request and fill of line 0x80000000
    vecs.push_back(mk(32'h80000000,0,0,0,0,0,           1,0,1,32'h0,       NOP));
    vecs.push_back(mk(32'h80000000,0,0,1,0,0,           1,1,1,32'h80000000,NOP));
    vecs.push_back(mk(32'h80000000,0,0,0,1,32'h11,      1,0,0,0,           NOP));
    vecs.push_back(mk(32'h80000000,0,0,0,1,32'h22,      1,0,0,0,           NOP));
    vecs.push_back(mk(32'h80000000,0,0,0,1,32'h33,      1,0,0,0,           NOP));
    vecs.push_back(mk(32'h80000000,0,0,0,1,32'h44,      1,0,0,0,           NOP));
    // Hits across the line, then a miss to the next line
    vecs.push_back(mk(32'h80000008,0,0,0,0,0,           0,0,0,0,           NOP));
    vecs.push_back(mk(32'h80000000,0,0,0,0,0,           0,0,0,0,           32'h33));
    vecs.push_back(mk(32'h80000004,0,0,0,0,0,           0,0,0,0,           32'h11));
    vecs.push_back(mk(32'h80000008,0,0,0,0,0,           0,0,0,0,           32'h22));
    vecs.push_back(mk(32'h8000000C,0,0,0,0,0,           0,0,0,0,           32'h33));
    vecs.push_back(mk(32'h80000010,0,0,0,0,0,           1,0,0,0,           32'h44));
    // Request held five cycles with the fetch address wandering
    vecs.push_back(mk(32'h80000010,0,0,0,0,0,           1,1,1,32'h80000010,32'h44));
    vecs.push_back(mk(32'h80000020,0,0,0,0,0,           1,1,1,32'h80000010,32'h44));
    vecs.push_back(mk(32'h80000000,0,0,0,0,0,           1,1,1,32'h80000010,32'h44));
    vecs.push_back(mk(32'h80000100,0,0,0,0,0,           1,1,1,32'h80000010,32'h44));
    vecs.push_back(mk(32'h80000004,0,0,0,0,0,           1,1,1,32'h80000010,32'h44));
    vecs.push_back(mk(32'h80000030,0,0,1,0,0,           1,1,1,32'h80000010,32'h44));
    vecs.push_back(mk(32'h80000000,0,0,0,1,32'h55,      1,0,0,0,           32'h44));
    vecs.push_back(mk(32'h80000000,0,0,0,1,32'h66,      1,0,0,0,           32'h44));
    vecs.push_back(mk(32'h80000000,0,0,0,1,32'h77,      1,0,0,0,           32'h44));
    vecs.push_back(mk(32'h80000000,0,0,0,1,32'h88,      1,0,0,0,           32'h44));
    // Original line was filled; hold freezes instr
    vecs.push_back(mk(32'h80000014,0,0,0,0,0,           0,0,0,0,           32'h44));
    vecs.push_back(mk(32'h80000010,0,0,0,0,0,           0,0,0,0,           32'h66));
    vecs.push_back(mk(32'h80000014,1,0,0,0,0,           0,0,0,0,           32'h55));
    vecs.push_back(mk(32'h80000018,1,0,0,0,0,           0,0,0,0,           32'h55));
    vecs.push_back(mk(32'h80000014,0,0,0,0,0,           0,0,0,0,           32'h55));
    // Invalidate during beat 2 of a fill
    vecs.push_back(mk(32'h80000040,0,0,0,0,0,           1,0,0,0,           32'h66));
    vecs.push_back(mk(32'h80000040,0,0,1,0,0,           1,1,1,32'h80000040,32'h66));
    vecs.push_back(mk(32'h80000040,0,0,0,1,32'hA0,      1,0,0,0,           32'h66));
    vecs.push_back(mk(32'h80000040,0,0,0,1,32'hA1,      1,0,0,0,           32'h66));
    vecs.push_back(mk(32'h80000040,0,1,0,1,32'hA2,      1,0,0,0,           32'h66));
    vecs.push_back(mk(32'h80000040,0,0,0,1,32'hA3,      1,0,0,0,           32'h66));
    vecs.push_back(mk(32'h80000040,0,0,0,0,0,           1,0,0,0,           32'h66));
    vecs.push_back(mk(32'h80000040,0,0,0,0,0,           1,1,1,32'h80000040,32'h66));
    // Start another fill, to be cut short by reset
    vecs.push_back(mk(32'h80000040,0,0,1,0,0,           1,1,1,32'h80000040,32'h66));
    vecs.push_back(mk(32'h80000040,0,0,0,1,32'hB0,      1,0,0,0,           32'h66));
    vecs.push_back(mk(32'h80000040,0,0,0,1,32'hB1,      1,0,0,0,           32'h66));
    part_a_last = vecs.size() - 1;
    // After reset: stray beats in IDLE and REQ are ignored, refill works
    vecs.push_back(mk(32'h80000040,0,0,0,1,32'hDEADBEEF,1,0,1,32'h0,       NOP));
    vecs.push_back(mk(32'h80000040,0,0,0,1,32'h0BADF00D,1,1,1,32'h80000040,NOP));
    vecs.push_back(mk(32'h80000040,0,0,1,0,0,           1,1,1,32'h80000040,NOP));
    vecs.push_back(mk(32'h80000040,0,0,0,1,32'hC0,      1,0,0,0,           NOP));
    vecs.push_back(mk(32'h80000040,0,0,0,1,32'hC1,      1,0,0,0,           NOP));
    vecs.push_back(mk(32'h80000040,0,0,0,1,32'hC2,      1,0,0,0,           NOP));
    vecs.push_back(mk(32'h80000040,0,0,0,1,32'hC3,      1,0,0,0,           NOP));
    vecs.push_back(mk(32'h80000048,0,0,0,0,0,           0,0,0,0,           NOP));
    vecs.push_back(mk(32'h8000004C,0,0,0,0,0,           0,0,0,0,           32'hC2));
    vecs.push_back(mk(32'h80000040,0,0,0,0,0,           0,0,0,0,           32'hC3));

    $display("[TB] directed vectors");
    idleInputs(32'h80000000);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    runRows(0, part_a_last);

    // Asynchronous reset in the middle of a fill
    $display("[TB] reset mid-fill");
    idleInputs(32'h80000040);
    rst_n = 1'b0;
    #1;
    cmp("midfill_rst_instr", instr, NOP);
    cmp("midfill_rst_stall", {31'd0, i_stall}, 32'd1);
    cmp("midfill_rst_reqvalid", {31'd0, mem_req_valid}, 32'd0);
    cmp("midfill_rst_reqaddr", mem_req_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    runRows(part_a_last + 1, vecs.size() - 1);

    // ---------------- randomized run ----------------
    $display("[TB] randomized run");
    lines[0] = 32'h80000000; lines[1] = 32'h80000010;
    lines[2] = 32'h80000020; lines[3] = 32'h90000100;
    idleInputs(32'h80000000);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_pending = 0; m_beats_left = 0; m_valid = 0; m_line = '0;
    m_req_line = '0; m_discard = 0; exp_instr = NOP;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      cmp("rand_instr", instr, exp_instr);

      a   = lines[$urandom_range(0, 3)] + 32'(4 * $urandom_range(0, LW - 1));
      h   = ($urandom_range(0, 4) == 0);
      iv  = ($urandom_range(0, 24) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      if (m_beats_left > 0) begin
        rv = ($urandom_range(0, 3) != 0);
        rd = memf(m_req_line + 32'(4 * (LW - m_beats_left)));
      end else begin
        rv = ($urandom_range(0, 5) == 0);
        rd = $urandom;
      end
      i_addr = a; hold = h; invalidate = iv; mem_req_ready = rdy;
      mem_rsp_valid = rv; mem_rsp_data = rd;
      #1;

      idle = !m_pending && (m_beats_left == 0);
      hit  = idle && m_valid && (line_of(a) == m_line);
      cmp("rand_stall", {31'd0, i_stall}, {31'd0, !hit});
      cmp("rand_reqvalid", {31'd0, mem_req_valid}, {31'd0, m_pending});
      if (m_pending) cmp("rand_reqaddr", mem_req_addr, m_req_line);

      // What the coming edge does
      if (idle) begin
        if (hit && !h) exp_instr = memf({a[31:2], 2'b00});
        if (iv) m_valid = 0;
        if (!hit) begin
          m_pending  = 1;
          m_req_line = line_of(a);
        end
      end else if (m_pending) begin
        if (iv) m_discard = 1;
        if (rdy) begin
          m_pending    = 0;
          m_beats_left = LW;
          m_valid      = 0;
        end
      end else begin
        if (rv) begin
          m_beats_left--;
          if (m_beats_left == 0) begin
            m_valid   = !m_discard && !iv;
            m_line    = m_req_line;
            m_discard = 0;
          end else if (iv) begin
            m_discard = 1;
          end
        end else if (iv) begin
          m_discard = 1;
        end
      end

      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-side responder that serves the fetch stage's instruction address with the fetched instruction word.
- Holds one line buffer of LINE_WORDS words in front of a backing instruction memory, which is reached over a valid/ready request channel and a beat-wise response channel.
- Hits return the word one cycle after the address is presented, matching a synchronous-read memory.
- Misses assert i_stall (ORed into fetch_stall) and fill the whole line before releasing the stall.

Parameters:
- LINE_WORDS, 4: words per line buffer; power of two, at least 2.
- NOP_INSTR, 32'h00000013: value driven on instr at reset (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- i_addr  in  32  instruction address from fetch; bits [1:0] ignored.
- hold  in  1  pipeline stalled by another source; instr must not update.
- invalidate  in  1  fence.i pulse; clears the line buffer.
- instr  out  32  instruction word for the address presented last cycle.
- i_stall  out  1  miss or fill in progress; fetch must hold.
- mem_req_valid  out  1  line request valid.
- mem_req_ready  in  1  backing memory accepts request.
- mem_req_addr  out  32  line-aligned request address.
- mem_rsp_valid  in  1  response beat valid.
- mem_rsp_data  in  32  response beat data, ascending word order.

Behaviour:
- Address split, with OFF = log2(LINE_WORDS)+2:
  - tag = i_addr[31:OFF]
  - idx = i_addr[OFF-1:2]
- hit = (state==IDLE) & line_valid & (tag==line_tag).
- i_stall is combinational: i_stall = (state!=IDLE) | ~hit.
- On reset (async, rst_n=0), outputs and state are:
  - state=IDLE, line_valid=0, instr=NOP_INSTR
  - mem_req_valid=0, mem_req_addr=0, beat count=0, discard=0
  - line data contents need no reset.
- FSM state IDLE:
  - hit & ~hold: instr <= line[idx] next cycle (latency 1).
  - hit & hold: instr holds.
  - miss: latch miss_tag=tag; go to REQ next cycle. instr holds.
- FSM state REQ:
  - mem_req_valid=1; mem_req_addr={miss_tag, OFF'b0}.
  - Address and valid stay stable until mem_req_ready.
  - On valid & ready: go to FILL, cnt=0, line_valid<=0.
- FSM state FILL:
  - Each mem_rsp_valid beat: line[cnt] <= mem_rsp_data; cnt increments.
  - On the beat with cnt==LINE_WORDS-1: line_tag<=miss_tag; line_valid<=~discard & ~invalidate; discard<=0; go to IDLE.
  - Back in IDLE the next cycle, the re-presented i_addr hits; instr updates the following cycle.
- mem_rsp_valid in IDLE or REQ is ignored (no state change).
- Invalidate handling:
  - In IDLE: line_valid<=0 next cycle.
  - In REQ or FILL: set discard. The fill completes and consumes all beats, but the line stays invalid. The refetch then misses again.
- An address change during REQ or FILL is ignored; the in-flight line always completes.
- There is no abort path: a reset mid-fill is the only way to abandon a fill, and it returns to IDLE with line_valid=0. Any stale beats after reset are ignored per the IDLE rule.
- Each fill issues exactly one request; there is never more than one outstanding.
- Back-to-back misses to different lines each need a full REQ/FILL cycle.
- Each miss costs at least 1 (miss detect) + 1 (REQ) + LINE_WORDS cycles of i_stall.

Test Plan:
- Reset release, i_addr=32'h80000000:
  - i_stall=1 and instr=32'h00000013 immediately.
  - Next cycle mem_req_valid=1, mem_req_addr=32'h80000000.
- With ready=1 and beats 0x11,0x22,0x33,0x44 on consecutive cycles:
  - i_stall drops the cycle after the last beat.
  - i_addr=32'h80000008 gives instr=0x33 one cycle later.
- Line 32'h80000000 valid; step i_addr 0x0,0x4,0x8,0xC, then 32'h80000010:
  - Four hits, i_stall=0, instr returns 0x11..0x44.
  - 0x10 misses and gives mem_req_addr=32'h80000010.
- mem_req_ready held low for 5 cycles, with i_addr changing during the wait:
  - mem_req_valid stays 1 and mem_req_addr stays stable.
  - The fill completes for the original line.
- hold=1 on a hit with i_addr changing from 0x0 to 0x4:
  - instr holds at 0x11.
  - After hold drops, instr=0x22 next cycle.
- invalidate pulse during beat 2 of a fill:
  - The fill completes, line_valid=0, and the same address misses again with a new request.
- rst_n low mid-FILL, followed by a stray mem_rsp_valid after release:
  - FSM returns to IDLE and line_valid=0.
  - The stray beat is ignored and the next access issues a new request.
